// File: rtl/stdp_pkg.sv
// Shared defaults and the timing-dependent step-size helper for the STDP synapse array.
package stdp_pkg;

    localparam int STDP_N_PRE   = 5;
    localparam int STDP_TW      = 8;
    localparam int STDP_WW      = 8;
    localparam int STDP_A_PLUS  = 16;
    localparam int STDP_A_MINUS = 8;
    localparam int STDP_TAU_SH  = 2;
    localparam int STDP_WIN     = 32;
    localparam int STDP_W_INIT  = 64;
    localparam int STDP_W_MAX   = 255;

    // Step size halves every 2^tau_sh cycles of spike separation.
    function automatic int unsigned stdp_delta(input int unsigned dt,
                                               input int unsigned base,
                                               input int unsigned tau_sh);
        return base >> (dt >> tau_sh);
    endfunction

endpackage

// File: rtl/stdp_if.sv
// Spike inputs and weight/update outputs of the STDP array, grouped as one bus.
interface stdp_if
    import stdp_pkg::*;
#(
    parameter int N_PRE = STDP_N_PRE,
    parameter int WW    = STDP_WW
);

    logic                  learn_en;
    logic [N_PRE-1:0]      pre_spike;
    logic                  post_spike;
    logic [N_PRE*WW-1:0]   weights;
    logic                  update_valid;
    logic [N_PRE-1:0]      update_mask;

    modport master (
        output learn_en, pre_spike, post_spike,
        input  weights, update_valid, update_mask
    );

    modport slave (
        input  learn_en, pre_spike, post_spike,
        output weights, update_valid, update_mask
    );

endinterface

// File: rtl/stdp_channel.sv
// One synapse: presynaptic spike timer, weight register and pair-based LTP/LTD update.
module stdp_channel
    import stdp_pkg::*;
#(
    parameter int TW      = STDP_TW,
    parameter int WW      = STDP_WW,
    parameter int A_PLUS  = STDP_A_PLUS,
    parameter int A_MINUS = STDP_A_MINUS,
    parameter int TAU_SH  = STDP_TAU_SH,
    parameter int WIN     = STDP_WIN,
    parameter int W_INIT  = STDP_W_INIT,
    parameter int W_MAX   = STDP_W_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_learn_en,
    input  logic          i_pre_spike,
    input  logic          i_post_spike,
    input  logic [TW-1:0] i_post_t,
    output logic [WW-1:0] o_weight,
    output logic          o_updated
);

    localparam logic [TW-1:0] T_SAT    = '1;
    localparam logic [TW-1:0] T_WIN    = TW'(WIN);
    localparam logic [WW:0]   W_MAX_X  = (WW+1)'(W_MAX);
    localparam logic [WW-1:0] W_INIT_W = WW'(W_INIT);

    logic [TW-1:0] r_pre_t;
    logic [WW-1:0] r_weight_p1;
    logic          r_upd_p1;

    logic          w_ltp;
    logic          w_ltd;
    logic [WW:0]   w_dp;
    logic [WW:0]   w_dm;
    logic [WW-1:0] w_next;

    function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] w, input logic [WW:0] d);
        logic [WW:0] s;
        s = {1'b0, w} + d;
        return (s > W_MAX_X) ? W_MAX_X[WW-1:0] : s[WW-1:0];
    endfunction

    function automatic logic [WW-1:0] sat_sub(input logic [WW-1:0] w, input logic [WW:0] d);
        logic [WW:0] s;
        s = {1'b0, w} - d;
        return ({1'b0, w} < d) ? '0 : s[WW-1:0];
    endfunction

    assign w_dp = (WW+1)'(stdp_delta(32'(r_pre_t), $unsigned(A_PLUS), $unsigned(TAU_SH)));
    assign w_dm = (WW+1)'(stdp_delta(32'(i_post_t), $unsigned(A_MINUS), $unsigned(TAU_SH)));

    // Coincident pre/post spikes cancel; a saturated timer is always outside the window.
    always_comb begin
        w_ltp  = i_post_spike && !i_pre_spike && (r_pre_t != '0) && (r_pre_t < T_WIN);
        w_ltd  = i_pre_spike && !i_post_spike && (i_post_t != '0) && (i_post_t < T_WIN);
        w_next = r_weight_p1;
        if (w_ltp) begin
            w_next = sat_add(r_weight_p1, w_dp);
        end else if (w_ltd) begin
            w_next = sat_sub(r_weight_p1, w_dm);
        end
    end

    // Stage p1: registered timer, weight and change flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_t     <= T_SAT;
            r_weight_p1 <= W_INIT_W;
            r_upd_p1    <= 1'b0;
        end else begin
            if (i_pre_spike) begin
                r_pre_t <= TW'(1);
            end else if (r_pre_t != T_SAT) begin
                r_pre_t <= r_pre_t + TW'(1);
            end
            r_upd_p1 <= i_learn_en && (w_next != r_weight_p1);
            if (i_learn_en) begin
                r_weight_p1 <= w_next;
            end
        end
    end

    assign o_weight  = r_weight_p1;
    assign o_updated = r_upd_p1;

endmodule

// File: rtl/stdp_array.sv
// Array of STDP synapses sharing one postsynaptic neuron; holds the post timer and packs outputs.
module stdp_array
    import stdp_pkg::*;
#(
    parameter int N_PRE   = STDP_N_PRE,
    parameter int TW      = STDP_TW,
    parameter int WW      = STDP_WW,
    parameter int A_PLUS  = STDP_A_PLUS,
    parameter int A_MINUS = STDP_A_MINUS,
    parameter int TAU_SH  = STDP_TAU_SH,
    parameter int WIN     = STDP_WIN,
    parameter int W_INIT  = STDP_W_INIT,
    parameter int W_MAX   = STDP_W_MAX
) (
    input  logic   clk,
    input  logic   rst,
    stdp_if.slave  bus
);

    localparam logic [TW-1:0] T_SAT = '1;

    if (WIN > (2**TW) - 1) begin : g_bad_win
        $error("WIN must not exceed the saturated timer value");
    end
    if (W_INIT > W_MAX) begin : g_bad_init
        $error("W_INIT must not exceed W_MAX");
    end
    if (W_MAX > (2**WW) - 1) begin : g_bad_max
        $error("W_MAX must fit in WW bits");
    end

    logic [TW-1:0]    r_post_t;
    logic [N_PRE-1:0] w_mask;

    // Stage p1: shared postsynaptic timer, read by every channel for LTD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_post_t <= T_SAT;
        end else if (bus.post_spike) begin
            r_post_t <= TW'(1);
        end else if (r_post_t != T_SAT) begin
            r_post_t <= r_post_t + TW'(1);
        end
    end

    for (genvar i = 0; i < N_PRE; i++) begin : g_ch
        stdp_channel #(
            .TW      (TW),
            .WW      (WW),
            .A_PLUS  (A_PLUS),
            .A_MINUS (A_MINUS),
            .TAU_SH  (TAU_SH),
            .WIN     (WIN),
            .W_INIT  (W_INIT),
            .W_MAX   (W_MAX)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_learn_en   (bus.learn_en),
            .i_pre_spike  (bus.pre_spike[i]),
            .i_post_spike (bus.post_spike),
            .i_post_t     (r_post_t),
            .o_weight     (bus.weights[i*WW +: WW]),
            .o_updated    (w_mask[i])
        );
    end

    assign bus.update_mask  = w_mask;
    assign bus.update_valid = |w_mask;

endmodule

// File: tb/tb_stdp_array.sv
// Randomized and directed bench for stdp_array against a spike-time based reference model.
module tb_stdp_array;

    localparam int N       = 5;
    localparam int WW      = 8;
    localparam int A_PLUS  = 16;
    localparam int A_MINUS = 8;
    localparam int TAU_SH  = 2;
    localparam int WIN     = 32;
    localparam int W_INIT  = 64;
    localparam int W_MAX   = 255;
    localparam int NEVER   = 1 << 20;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   chk_en;

    // Reference model: last spike cycle per channel instead of timers.
    int mw[N];
    int last_pre[N];
    int last_post;
    int exp_mask;
    int cyc;

    stdp_if #(.N_PRE(N), .WW(WW)) bus ();

    stdp_array dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mw[i]       = W_INIT;
                last_pre[i] = -1;
            end
            last_post = -1;
            exp_mask  = 0;
        end else begin
            exp_mask = 0;
            for (int i = 0; i < N; i++) begin
                int nw;
                int dt;
                nw = mw[i];
                if (bus.learn_en) begin
                    if (bus.post_spike && !bus.pre_spike[i]) begin
                        dt = (last_pre[i] < 0) ? NEVER : cyc - last_pre[i];
                        if (dt >= 1 && dt < WIN) begin
                            nw = mw[i] + A_PLUS / (1 << (dt / (1 << TAU_SH)));
                            if (nw > W_MAX) nw = W_MAX;
                        end
                    end else if (bus.pre_spike[i] && !bus.post_spike) begin
                        dt = (last_post < 0) ? NEVER : cyc - last_post;
                        if (dt >= 1 && dt < WIN) begin
                            nw = mw[i] - A_MINUS / (1 << (dt / (1 << TAU_SH)));
                            if (nw < 0) nw = 0;
                        end
                    end
                end
                if (nw != mw[i]) begin
                    exp_mask = exp_mask | (1 << i);
                    mw[i]    = nw;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (bus.pre_spike[i]) last_pre[i] = cyc;
            end
            if (bus.post_spike) last_post = cyc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("weight%0d", i), int'(bus.weights[i*WW +: WW]), mw[i]);
            end
            chk("update_mask", int'(bus.update_mask), exp_mask);
            chk("update_valid", int'(bus.update_valid), int'(exp_mask != 0));
        end
    end

    task automatic step(input logic [N-1:0] pre, input logic post);
        bus.pre_spike  = pre;
        bus.post_spike = post;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0);
    endtask

    function automatic int wt(input int ch);
        return int'(bus.weights[ch*WW +: WW]);
    endfunction

    initial begin
        int expw;
        checks         = 0;
        failures       = 0;
        chk_en         = 1'b0;
        cyc            = 0;
        rst            = 1'b1;
        bus.learn_en   = 1'b1;
        bus.pre_spike  = '0;
        bus.post_spike = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        for (int i = 0; i < N; i++) chk("reset_weight", wt(i), 64);
        chk("reset_mask", int'(bus.update_mask), 0);
        chk("reset_valid", int'(bus.update_valid), 0);

        rst = 1'b0;
        idle(2);

        // Causal pair, dt=3.
        step(5'b00001, 1'b0);
        idle(2);
        step(5'b00000, 1'b1);
        chk("causal_w0", wt(0), 80);
        chk("causal_mask", int'(bus.update_mask), 1);
        chk("model_causal_w0", mw[0], 80);
        idle(40);

        // Decay, dt=9, then an out-of-window pair at dt=40.
        step(5'b00010, 1'b0);
        idle(8);
        step(5'b00000, 1'b1);
        chk("decay_w1", wt(1), 68);
        chk("model_decay_w1", mw[1], 68);
        idle(40);
        step(5'b00010, 1'b0);
        idle(39);
        step(5'b00000, 1'b1);
        chk("outwin_valid", int'(bus.update_valid), 0);
        chk("outwin_w1", wt(1), 68);
        idle(40);

        // Anti-causal pair, dt=5.
        step(5'b00000, 1'b1);
        idle(4);
        step(5'b00100, 1'b0);
        chk("anti_w2", wt(2), 60);
        chk("anti_mask", int'(bus.update_mask), 4);
        chk("model_anti_w2", mw[2], 60);
        idle(40);

        // LTP saturation on channel 3.
        for (int k = 1; k <= 13; k++) begin
            step(5'b01000, 1'b0);
            step(5'b00000, 1'b1);
            expw = (64 + 16 * k > 255) ? 255 : 64 + 16 * k;
            chk("ltp_sat_w3", wt(3), expw);
            if (k == 13) chk("ltp_sat_mask3", int'(bus.update_mask[3]), 0);
            idle(32);
        end

        // Mirrored LTD floor on channel 3.
        expw = 255;
        for (int k = 1; k <= 34; k++) begin
            step(5'b00000, 1'b1);
            step(5'b01000, 1'b0);
            expw = (expw - 8 < 0) ? 0 : expw - 8;
            chk("ltd_floor_w3", wt(3), expw);
            if (k == 34) chk("ltd_floor_mask3", int'(bus.update_mask[3]), 0);
            idle(32);
        end
        idle(8);

        // Coincident spikes cancel, then dt=2 LTP.
        step(5'b10000, 1'b1);
        chk("coinc_w4", wt(4), 64);
        chk("coinc_mask4", int'(bus.update_mask[4]), 0);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b1);
        chk("coinc_next_w4", wt(4), 80);
        chk("model_coinc_w4", mw[4], 80);
        idle(40);

        // learn_en low: weights hold at reset value.
        rst = 1'b1;
        step('0, 1'b0);
        rst = 1'b0;
        bus.learn_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(5'b00001, 1'b0);
            step(5'b00000, 1'b1);
            chk("nolearn_valid", int'(bus.update_valid), 0);
            idle(5);
        end
        for (int i = 0; i < N; i++) chk("nolearn_weight", wt(i), 64);
        bus.learn_en = 1'b1;
        idle(40);

        // Reset between pre and post discards timer history; spikes during reset ignored.
        step(5'b00001, 1'b0);
        rst = 1'b1;
        step('0, 1'b0);
        rst = 1'b0;
        step(5'b00000, 1'b1);
        chk("rstmid_valid", int'(bus.update_valid), 0);
        for (int i = 0; i < N; i++) chk("rstmid_weight", wt(i), 64);
        rst = 1'b1;
        step(5'b00010, 1'b0);
        rst = 1'b0;
        step(5'b00000, 1'b1);
        chk("rstspike_valid", int'(bus.update_valid), 0);
        idle(4);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] pre;
            rst          = ($urandom_range(0, 599) == 0);
            bus.learn_en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < N; i++) pre[i] = ($urandom_range(0, 7) == 0);
            step(pre, ($urandom_range(0, 5) == 0));
        end
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stdp_array.md
STDP_ARRAY -- requirements
Module: stdp_array

Interface
REQ-001 The block SHALL have parameters N_PRE (default 5), the number of presynaptic channels.
REQ-002 The block SHALL have parameters TW (default 8), the spike timer width, and WW (default 8), the weight width.
REQ-003 The block SHALL have parameters A_PLUS (16) and A_MINUS (8), the base LTP and LTD step sizes.
REQ-004 The block SHALL have parameters TAU_SH (2), the decay shift; WIN (32), the learning window in cycles; W_INIT (64), the reset weight; W_MAX (255), the weight ceiling.
REQ-005 The block SHALL have the following ports:
  clk  in  1  clock; one clock.
  rst  in  1  reset, synchronous, active-high.
  learn_en  in  1  enables weight updates.
  pre_spike  in  N_PRE  presynaptic spikes, one bit per channel.
  post_spike  in  1  postsynaptic spike.
  weights  out  N_PRE*WW  packed weights; channel i occupies bits [i*WW +: WW].
  update_valid  out  1  one-cycle pulse when any weight changed.
  update_mask  out  N_PRE  channels whose weight changed, aligned with update_valid.

Function
REQ-006 Each channel SHALL keep a registered pre timer.
  - On pre_spike[i] the timer loads 1.
  - Otherwise it increments by 1 per cycle and saturates at 2^TW-1 (no wrap).
REQ-007 The post timer SHALL follow the same rule, driven by post_spike.
REQ-008 A timer value of 2^TW-1 SHALL mean "no spike yet".
  - Timer reads k in the cycle k cycles after its spike.
REQ-009 LTP: when post_spike=1 in cycle c, the registered pre timer dt of channel i SHALL be used if 1 <= dt < WIN, as follows.
  - delta = A_PLUS >> (dt >> TAU_SH).
  - New weight = min(w + delta, W_MAX).
REQ-010 LTD: when pre_spike[i]=1 in cycle c, the registered post timer dt SHALL be used if 1 <= dt < WIN, as follows.
  - delta = A_MINUS >> (dt >> TAU_SH).
  - New weight = max(w - delta, 0).
REQ-011 If pre_spike[i] and post_spike are both 1 in the same cycle, channel i's weight SHALL be unchanged, and both timers SHALL load 1.
REQ-012 Timer values that are out of window, or deltas that shift to 0, SHALL produce no change and SHALL NOT set the channel's update_mask bit.
REQ-013 Weight arithmetic SHALL use a WW+1-bit intermediate, and results SHALL saturate, never wrap.
REQ-014 Latency SHALL be one cycle.
  - A weight change caused by a spike in cycle c is visible on weights in cycle c+1.
  - update_valid and update_mask are asserted in cycle c+1 only.
REQ-015 update_valid SHALL equal the OR of update_mask.
  - A weight already at the rail, where the clamp yields the same value, SHALL count as unchanged.
REQ-016 When learn_en=0, timers SHALL keep running, weights SHALL hold, and update_valid/update_mask SHALL stay 0.
REQ-017 All channels SHALL update independently and in parallel within the same cycle.

Reset
REQ-018 While rst=1 at a clk edge, the block SHALL set:
  - all weights to W_INIT;
  - all timers to 2^TW-1;
  - update_valid to 0 and update_mask to 0.
REQ-019 Reset asserted mid-operation SHALL discard all timer history, so no LTP/LTD is applied in the first cycle after reset.
REQ-020 Spikes presented during reset SHALL be ignored.

Structure
REQ-021 The shared package stdp_pkg SHALL hold default parameter constants and the delta-computation function (dt, base, tau_sh -> delta).
REQ-022 The block SHALL instantiate the sub-module stdp_channel once per channel, generated N_PRE times.
  - stdp_channel contains one pre timer, one weight register and the LTP/LTD update logic.
  - stdp_array holds the shared post timer and the output packing.
REQ-023 Elaboration SHALL reject WIN > 2^TW-1 and W_INIT > W_MAX.

Verification (default parameters)
REQ-024 Causal pair: pre_spike[0] in cycle 10, post_spike in cycle 13 (dt=3) -> weight0 becomes 80 in cycle 14; update_mask=5'b00001.
REQ-025 Decay: pre_spike[1] in cycle 10, post in cycle 19 (dt=9, delta 16>>2=4) -> weight1 becomes 68. A pair with dt=40 -> no change and update_valid=0.
REQ-026 Anti-causal pair: post in cycle 10, pre_spike[2] in cycle 15 (dt=5, delta 8>>1=4) -> weight2 becomes 60; update_mask=5'b00100.
REQ-027 Saturation: repeated dt=1 causal pairs on channel 3 -> weight3 climbs 64, 80, ..., 240, then 255, then stays 255 with update_mask[3]=0. A mirrored LTD sequence floors at 0.
REQ-028 Simultaneous pre_spike[4] and post in the same cycle -> weight4 unchanged; the next post 2 cycles later applies LTP with dt=2 (+16).
REQ-029 Mode and reset:
  - learn_en=0 with causal pairs -> weights stay 64 and update_valid never pulses.
  - rst pulsed between a pre spike and a post spike -> no update, and all weights read 64.
